// File: rtl/wb_ext_mem_arb.sv
// wb_ext_mem_arb: round-robin N-master Wishbone arbiter for the external memory port.
// A grant is held for the whole master cycle, so bursts are never split. A watchdog
// aborts slave cycles that never respond and drains the owner until it drops cyc.
//
// Ports:
//   clk, rst_sys_n          sole clock, async active-low reset
//   m_*_i                   master request buses, master k in slice k
//   m_dat_o                 shared read data (always the slave read data)
//   m_ack_o/m_err_o/m_rty_o per-master responses, routed to the owner only
//   s_*_o                   slave side, mirrors the owner while BUSY, 0 otherwise
//   s_dat_i, s_ack_i/err/rty slave read data and responses
//   grant_o                 one-hot owner, 0 while idle
//   timeout_o               one-cycle pulse when the watchdog aborts a cycle
module wb_ext_mem_arb #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 27,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                clk,
  input  logic                                rst_sys_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]            m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]            m_bte_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_MASTERS-1:0]              m_rty_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic                                s_we_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic [2:0]                          s_cti_o,
  output logic [1:0]                          s_bte_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_err_i,
  input  logic                                s_rty_i,
  output logic [NUM_MASTERS-1:0]              grant_o,
  output logic                                timeout_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_nxt;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;
  logic             arb_found;
  logic             own_cyc;
  logic             own_stb;
  logic             slv_resp;
  logic             wd_hit;

  // Per-master views of the packed request buses
  logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];
  logic [2:0]            cti_arr [NUM_MASTERS];
  logic [1:0]            bte_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
    assign cti_arr[k] = m_cti_i[k*3 +: 3];
    assign bte_arr[k] = m_bte_i[k*2 +: 2];
  end

  // 'last' always holds the current owner's index outside IDLE
  assign own_cyc  = m_cyc_i[last];
  assign own_stb  = m_stb_i[last];
  assign slv_resp = s_ack_i | s_err_i | s_rty_i;
  assign m_dat_o  = s_dat_i;

  // A response in the terminal count cycle wins over the abort
  assign wd_hit = (TIMEOUT != 0) && own_stb && !slv_resp && (wd_cnt == CNT_W'(TO_LAST));

  assign wd_cnt_nxt = ((state == ST_BUSY) && own_stb && !slv_resp) ? wd_cnt + CNT_W'(1)
                                                                      : '0;

  // Round-robin search starting just after the previous owner
  always_comb begin
    arb_idx   = last;
    arb_found = 1'b0;
    cand      = last;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_MASTERS);
      if (!arb_found && m_cyc_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, slave-side mux and response routing
  always_comb begin
    next_state = state;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    s_we_o     = 1'b0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_cti_o    = '0;
    s_bte_o    = '0;
    m_ack_o    = '0;
    m_err_o    = '0;
    m_rty_o    = '0;
    timeout_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_found) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        s_adr_o = adr_arr[last];
        s_dat_o = dat_arr[last];
        s_sel_o = sel_arr[last];
        s_we_o  = m_we_i[last];
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_cti_o = cti_arr[last];
        s_bte_o = bte_arr[last];
        m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
        m_err_o = grant_o & {NUM_MASTERS{s_err_i}};
        m_rty_o = grant_o & {NUM_MASTERS{s_rty_i}};
        if (!own_cyc) begin
          next_state = ST_IDLE;
        end else if (wd_hit) begin
          next_state = ST_ABORT;
        end
      end
      ST_ABORT: begin
        m_err_o    = grant_o;
        timeout_o  = 1'b1;
        next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!own_cyc) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Grant, priority pointer and watchdog counter
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      grant_o <= '0;
      last    <= LAST_RST;
      wd_cnt  <= '0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if ((state == ST_IDLE) && arb_found) begin
        grant_o <= NUM_MASTERS'(1) << arb_idx;
        last    <= arb_idx;
      end else if (next_state == ST_IDLE) begin
        grant_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_ext_mem_arb.sv
// Directed bench for wb_ext_mem_arb (4 masters, TIMEOUT=16). Expected responses are
// queued as stimulus is issued; a negedge monitor pops and compares whenever the
// DUT presents any master response or a timeout pulse.
module tb_wb_ext_mem_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 27;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic            clk;
  logic            rst_sys_n;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [N-1:0]  rty;
    logic          tmo;
    logic          chk_dat;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  wb_ext_mem_arb #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (16)
  ) dut (
    .clk      (clk),
    .rst_sys_n(rst_sys_n),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_cti_i  (m_cti),
    .m_bte_i  (m_bte),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [N-1:0] ack, input logic [N-1:0] err,
                            input logic [N-1:0] rty, input logic tmo,
                            input logic chk_dat, input logic [DW-1:0] dat);
    exp_t e;
    e.ack = ack; e.err = err; e.rty = rty; e.tmo = tmo; e.chk_dat = chk_dat; e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb,
                       input logic [AW-1:0] adr, input logic [2:0] cti);
    m_cyc[k]          = cyc;
    m_stb[k]          = stb;
    m_adr[k*AW +: AW] = adr;
    m_cti[k*3 +: 3]   = cti;
  endtask

  task automatic idle_all();
    for (int k = 0; k < int'(N); k++) set_m(k, 1'b0, 1'b0, '0, 3'b000);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_sys_n && (|{m_ack_o, m_err_o, m_rty_o, timeout_o})) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got ack=%b err=%b rty=%b tmo=%b expected no response (t=%0t)",
                 m_ack_o, m_err_o, m_rty_o, timeout_o, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_rsp", {m_ack_o, m_err_o, m_rty_o, timeout_o},
            {mon_e.ack, mon_e.err, mon_e.rty, mon_e.tmo});
        if (mon_e.chk_dat) chk("sb_dat", m_dat_o, mon_e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst_sys_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // Reset held with every master requesting and a stray slave ack
    for (int k = 0; k < int'(N); k++) set_m(k, 1'b1, 1'b1, AW'(k * 16 + 4), 3'b000);
    s_ack_i = 1'b1;
    step(); step(); #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_m_resp", {m_ack_o, m_err_o, m_rty_o, timeout_o}, 0);
    step(); s_ack_i = 1'b0; rst_sys_n = 1'b1; #2;
    chk("rst_release_idle", grant_o, 0);
    step(); #2;
    chk("rst_first_grant", grant_o, 4'b0001);
    chk("rst_first_adr", s_adr_o, 4);
    idle_all();
    step(); #2;
    chk("rst_back_idle", grant_o, 0);

    // Single read by master 1, ack 3 cycles after strobe, owner drops cyc with the ack
    step(); set_m(1, 1'b1, 1'b1, 27'h100, 3'b000); #2;
    step(); #2;
    chk("rd_grant", grant_o, 4'b0010);
    chk("rd_s_adr", s_adr_o, 27'h100);
    chk("rd_s_cyc", s_cyc_o, 1);
    step(); #2;
    chk("rd_no_early_ack", m_ack_o, 0);
    step();
    step();
    expect_rsp(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF);
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF; set_m(1, 1'b0, 1'b0, '0, 3'b000); #2;
    chk("rd_ack_routed", m_ack_o, 4'b0010);
    step(); s_ack_i = 1'b0; s_dat_i = '0; #2;
    chk("rd_idle_grant", grant_o, 0);
    chk("rd_idle_s_cyc", s_cyc_o, 0);

    // Round robin: fresh reset, masters 0 and 2 request
    step(); rst_sys_n = 1'b0;
    step(); rst_sys_n = 1'b1;
    set_m(0, 1'b1, 1'b1, 27'h10, 3'b000); set_m(2, 1'b1, 1'b1, 27'h20, 3'b000); #2;
    step();
    expect_rsp(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    s_ack_i = 1'b1; set_m(0, 1'b0, 1'b0, '0, 3'b000); #2;
    chk("rr_first_m0", grant_o, 4'b0001);
    step(); s_ack_i = 1'b0; #2;
    chk("rr_idle_gap", {grant_o, s_cyc_o}, 0);
    step();
    expect_rsp(4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, '0);
    s_rty_i = 1'b1; #2;
    chk("rr_then_m2", grant_o, 4'b0100);
    chk("rr_m2_adr", s_adr_o, 27'h20);
    step(); s_rty_i = 1'b0;
    set_m(2, 1'b0, 1'b0, '0, 3'b000);
    set_m(0, 1'b1, 1'b1, 27'h30, 3'b000); set_m(1, 1'b1, 1'b1, 27'h40, 3'b000); #2;
    chk("rr_m2_hold_drop", grant_o, 4'b0100);
    step(); #2;
    chk("rr_handover_idle", grant_o, 0);
    step(); #2;
    chk("rr_wrap_m0", grant_o, 4'b0001);
    chk("rr_wrap_adr", s_adr_o, 27'h30);
    step(); set_m(0, 1'b0, 1'b0, '0, 3'b000); #2;
    step(); #2;
    chk("rr_idle_again", grant_o, 0);
    step(); #2;
    chk("rr_next_m1", grant_o, 4'b0010);
    set_m(1, 1'b0, 1'b0, '0, 3'b000);
    step(); #2;
    chk("rr_end_idle", grant_o, 0);

    // Burst integrity: master 0 4-beat incrementing burst, master 1 waiting
    step();
    set_m(0, 1'b1, 1'b1, 27'h200, 3'b010); set_m(1, 1'b1, 1'b1, 27'h300, 3'b000); #2;
    for (int b = 0; b < 4; b++) begin
      step();
      set_m(0, 1'b1, 1'b1, AW'(32'h200 + 4 * b), (b == 3) ? 3'b111 : 3'b010);
      expect_rsp(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hB000_0000 + b);
      s_ack_i = 1'b1; s_dat_i = 32'hB000_0000 + b; #2;
      chk("burst_grant_hold", grant_o, 4'b0001);
      chk("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
    end
    step(); s_ack_i = 1'b0; s_dat_i = '0; set_m(0, 1'b0, 1'b0, '0, 3'b000); #2;
    chk("burst_drop_cycle", grant_o, 4'b0001);
    step(); #2;
    chk("burst_idle_gap", grant_o, 0);
    step(); #2;
    chk("burst_m1_granted", grant_o, 4'b0010);
    set_m(1, 1'b0, 1'b0, '0, 3'b000);
    step(); #2;
    chk("burst_end_idle", grant_o, 0);

    // Watchdog: master 3, slave silent; abort lands 16 cycles after first strobe
    step(); set_m(3, 1'b1, 1'b1, 27'h400, 3'b000); #2;
    for (int c = 1; c <= 16; c++) begin
      step(); #2;
      if (c == 1 || c == 16) chk("wd_busy_before_abort", {s_cyc_o, timeout_o, m_err_o}, 6'b100000);
    end
    step();
    expect_rsp(4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0, '0);
    #2;
    chk("wd_abort_tmo", timeout_o, 1);
    chk("wd_abort_s_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("wd_abort_err", m_err_o, 4'b1000);
    for (int d = 1; d <= 5; d++) begin
      step();
      if (d == 1) s_ack_i = 1'b1;
      #2;
      chk("wd_drain_s_cyc", {s_cyc_o, s_stb_o, timeout_o}, 0);
      chk("wd_drain_no_resp", {m_ack_o, m_err_o, m_rty_o}, 0);
      chk("wd_drain_grant", grant_o, 4'b1000);
    end
    s_ack_i = 1'b0; set_m(3, 1'b0, 1'b0, '0, 3'b000);
    step(); #2;
    chk("wd_idle_after_drain", grant_o, 0);

    // Watchdog boundary: ack in the terminal count cycle prevents the abort
    step(); set_m(3, 1'b1, 1'b1, 27'h404, 3'b000); #2;
    for (int c = 1; c <= 15; c++) step();
    step();
    expect_rsp(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1234_5678);
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #2;
    chk("wd_late_ack", m_ack_o, 4'b1000);
    step(); s_ack_i = 1'b0; s_dat_i = '0; #2;
    chk("wd_no_abort", {timeout_o, m_err_o}, 0);
    chk("wd_still_busy", s_cyc_o, 1);
    set_m(3, 1'b0, 1'b0, '0, 3'b000);
    step(); #2;
    chk("wd2_idle", grant_o, 0);

    // Reset in beat 2 of a burst by master 0 (master 1 also waiting)
    step();
    set_m(0, 1'b1, 1'b1, 27'h500, 3'b010); set_m(1, 1'b1, 1'b1, 27'h600, 3'b000); #2;
    step();
    expect_rsp(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0000_00C0);
    s_ack_i = 1'b1; s_dat_i = 32'h0000_00C0; #2;
    chk("mid_beat1_grant", grant_o, 4'b0001);
    step(); s_ack_i = 1'b0; s_dat_i = '0; set_m(0, 1'b1, 1'b1, 27'h504, 3'b010);
    #1; rst_sys_n = 1'b0; #1;
    chk("mid_rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 0);
    chk("mid_rst_grant", grant_o, 0);
    idle_all();
    step(); rst_sys_n = 1'b1; #2;
    chk("mid_release_idle", grant_o, 0);
    step(); #2;
    chk("mid_no_request_idle", grant_o, 0);
    step(); set_m(0, 1'b1, 1'b1, 27'h700, 3'b000); set_m(1, 1'b1, 1'b1, 27'h704, 3'b000); #2;
    step(); #2;
    chk("mid_restart_m0", grant_o, 4'b0001);
    idle_all();
    step(); step(); #2;

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ext_mem_arb.md
# wb_ext_mem_arb

Parametrised N-master Wishbone arbiter for the SoC's single external memory port. It is the successor to the fixed one-master (debug MAM) hookup. Masters such as the MAM, CPU instruction and data ports, and DMA share one `wb_ext_*` interface through it. Arbitration is round-robin, a grant is held for a whole `cyc` (burst-safe), and a watchdog terminates slave cycles that never respond.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of master ports, 2..8.
- `ADDR_WIDTH`, 27: address width, matching MEM_ADDR_WIDTH for 128 MiB.
- `DATA_WIDTH`, 32: data width; select width is `DATA_WIDTH/8`.
- `TIMEOUT`, 255: cycles without a slave response before abort; 0 disables the watchdog.

Ports (N = `NUM_MASTERS`, master k occupies slice k):
- `clk`  in  1  sole clock.
- `rst_sys_n`  in  1  reset, asynchronous, active-low.
- `m_adr_i`  in  N*ADDR_WIDTH  master addresses.
- `m_dat_i`  in  N*DATA_WIDTH  master write data.
- `m_sel_i`  in  N*DATA_WIDTH/8  byte selects.
- `m_we_i`, `m_cyc_i`, `m_stb_i`  in  N each  per-master controls.
- `m_cti_i`  in  N*3  cycle type.
- `m_bte_i`  in  N*2  burst type.
- `m_dat_o`  out  DATA_WIDTH  read data, shared across masters.
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  N each  per-master responses.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`, `s_cti_o`, `s_bte_o`  out  widths as above  external slave side.
- `s_dat_i`  in  DATA_WIDTH  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each  slave responses.
- `grant_o`  out  N  one-hot current owner; 0 when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine with four states: IDLE, BUSY, ABORT, DRAIN.
- **IDLE**
  - All `s_*` control outputs are 0; `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_cti_o` and `s_bte_o` are also 0.
  - If any `m_cyc_i` is high, select the first requesting master searching from `last+1` modulo N upward.
  - Register the winner in `grant_o` and `last`, then go to BUSY.
- **BUSY**
  - All `s_*` outputs mirror the granted master combinationally.
  - `s_ack_i`, `s_err_i` and `s_rty_i` route only to the granted bit; other masters' responses are 0.
  - `m_dat_o` = `s_dat_i` at all times.
  - If the granted `m_cyc_i` goes low, go to IDLE. The grant is never revoked mid-cycle, so bursts (`cti` 001/010 ending at 111) are never split.
- **Watchdog** (TIMEOUT>0)
  - Counter width is `$clog2(TIMEOUT+1)`.
  - Clears on any slave response, on `s_stb_o`=0, or outside BUSY.
  - Increments each BUSY cycle with `s_stb_o`=1 and no response.
  - When the counter equals TIMEOUT-1 and there is still no response, go to ABORT.
- **ABORT** (exactly 1 cycle)
  - `s_cyc_o`/`s_stb_o` = 0.
  - Granted `m_err_o` = 1 and `timeout_o` = 1.
  - Next state: DRAIN.
- **DRAIN**
  - `s_cyc_o`/`s_stb_o` = 0 and no responses are routed; slave inputs are ignored.
  - Stay until the granted `m_cyc_i` = 0, then go to IDLE.
- `grant_o` stays one-hot in BUSY, ABORT and DRAIN, and is 0 in IDLE.
- A master losing `cyc` in BUSY leaves arbitration priority with the next index.

## Timing
- Reset (asynchronous, immediate on `rst_sys_n`=0):
  - State = IDLE, `grant_o`=0, counter=0, `timeout_o`=0.
  - `last`=N-1, so master 0 wins first.
  - All `s_*` and `m_ack_o`/`m_err_o`/`m_rty_o` = 0.
- Arbitration latency: a request seen in IDLE in cycle t gives `grant_o` and `s_cyc_o` in cycle t+1.
- Response path is combinational, so slave ack in cycle t gives master ack in cycle t.
- Between owners there is always exactly one IDLE cycle. This holds even if a new master raises `cyc` in the same cycle the owner drops it, and also for a master re-requesting immediately.
- Simultaneous owner `cyc` drop and slave ack: the ack is routed, then the state goes to IDLE.
- A slave response arriving in the cycle the counter hits TIMEOUT-1 wins: no abort.
- ABORT occurs TIMEOUT cycles after the first unanswered `s_stb_o` cycle.
- Reset mid-burst: slave outputs drop to 0 asynchronously; after reset release, arbitration restarts from master 0.

## Test plan
- **Reset:** hold `rst_sys_n`=0 with all masters requesting -> all outputs 0, `grant_o`=0. Release -> `grant_o`=0b01 one cycle later.
- **Single read:** N=4, master 1 reads 0x100, slave acks 3 cycles after `s_stb_o` with data 0xDEADBEEF.
  - `grant_o`=0b0010 one cycle after the request.
  - `s_adr_o`=0x100.
  - `m_ack_o`=0b0010 in the ack cycle, `m_dat_o`=0xDEADBEEF.
  - `m_ack_o[0,2,3]` stay 0.
- **Round-robin:** masters 0 and 2 request after reset.
  - 0 is granted; after 0 drops `cyc`, exactly one IDLE cycle follows, then 2 is granted.
  - Then masters 0 and 1 request -> 0 is granted (search starts from index 3, wrapping).
- **Burst integrity:** master 0 runs a 4-beat incrementing burst (`cti` 010,010,010,111) while master 1 requests throughout.
  - `grant_o` stays 0b01 for all 4 acks.
  - Master 1 is granted 2 cycles after master 0's `cyc` falls (1 IDLE cycle + arbitration).
- **Watchdog:** TIMEOUT=16, slave never responds, `s_stb_o` first high in cycle 1.
  - Cycle 17: `m_err_o` bit and `timeout_o` pulse for 1 cycle, `s_cyc_o`=0.
  - Master holds `cyc` 5 more cycles -> no responses and `s_cyc_o`=0 during that time.
  - Master drops `cyc` -> IDLE.
  - Repeat with an ack in cycle 16 -> no abort.
- **Reset mid-operation:** assert `rst_sys_n`=0 during beat 2 of a burst -> `s_cyc_o`/`s_stb_o` are 0 in the same cycle. After release, `grant_o`=0 until a new request arrives.
